// File: rtl/pcs_lb_pkg.sv
// pcs_lb_pkg
// Shared types for the PCS RX->TX loopback buffer.
//   lb_entry_t  : one buffered block {ctrl, idle, start, term, err, keep, data}
//   IDLE_ENTRY  : filler block inserted/deleted between frames
//   ERR_ENTRY   : block emitted when the FIFO runs dry inside a frame
//   next_in_frame() : frame-tracker update shared by the write and read sides
// The entry layout follows LB_IS_10G / LB_DATA_W below. pcs_loopback_fifo takes
// its IS_10G / DATA_W defaults from here, so a different build width is changed
// in this package, not only on the instance.
package pcs_lb_pkg;

    localparam int LB_IS_10G   = 1;
    localparam int LB_DATA_W   = 64;
    localparam int LANE0_CNT_N = (LB_IS_10G != 0) ? 2 : 1;
    localparam int KEEP_W      = LB_DATA_W / 8;

    typedef struct packed {
        logic                   ctrl;
        logic                   idle;
        logic [LANE0_CNT_N-1:0] start;
        logic                   term;
        logic                   err;
        logic [KEEP_W-1:0]      keep;
        logic [LB_DATA_W-1:0]   data;
    } lb_entry_t;

    localparam int ENTRY_W = $bits(lb_entry_t);

    localparam lb_entry_t IDLE_ENTRY = '{ctrl: 1'b1, idle: 1'b1, default: '0};
    localparam lb_entry_t ERR_ENTRY  = '{ctrl: 1'b1, err: 1'b1, default: '0};

    // A start anywhere in the block opens a frame even when the same block
    // also terminates it, so start wins over term.
    function automatic logic next_in_frame(input logic                   cur,
                                           input logic [LANE0_CNT_N-1:0] start,
                                           input logic                   term);
        logic nxt;
        nxt = cur;
        if (|start) begin
            nxt = 1'b1;
        end else if (term) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pcs_lb_fifo.sv
// pcs_lb_fifo
// Synchronous FIFO storage for the loopback buffer. The head entry is presented
// combinationally on rd_data; a pop advances it at the clock edge.
//   clk, nreset : clock, asynchronous active-low reset
//   flush       : return pointers and fill to zero, ignore writes and pops
//   wr_en       : push wr_data (accepted when not full, or full with a pop)
//   rd_en       : pop the head (ignored when empty)
//   rd_data     : head entry
//   full, empty : occupancy status
//   fill        : occupancy count, one bit wider than the pointers
module pcs_lb_fifo #(
    parameter int WIDTH = 78,
    parameter int DEPTH = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int FILL_W = AW + 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [FILL_W-1:0] fill
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (fill == FILL_W'(DEPTH));
    assign empty   = (fill == '0);
    assign rd_data = mem[rd_ptr];

    // A push into a full FIFO is still legal when the head leaves in the same
    // cycle, since the freed slot is the one being written.
    assign do_rd = rd_en && !flush && !empty;
    assign do_wr = wr_en && !flush && (!full || do_rd);

    // Storage array, no reset needed: only entries below fill are ever read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); fill is tracked
    // separately so full and empty are unambiguous.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                fill <= fill + 1'b1;
            end else if (do_rd && !do_wr) begin
                fill <= fill - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcs_loopback_fifo.sv
// pcs_loopback_fifo
// Elastic RX->TX loopback buffer. Absorbs valid/ready gaps of the two gearboxes,
// deletes inter-frame idles when nearly full, inserts idles (or an error block
// inside a frame) when empty, and reports overflow/underrun.
//   clk, nreset           : PCS clock, asynchronous active-low reset
//   signal_v_i            : RX block lock; low flushes the FIFO
//   valid_i, *_v_i, keep_i, data_i : RX block
//   ready_i               : pcs_tx takes the output block this cycle
//   *_v_o, keep_o, data_o : block presented to pcs_tx
//   fill_o                : FIFO occupancy
//   ovf_o, udf_o          : sticky overflow / underrun flags
//   clr_i                 : clear flags and counters (wins over set/increment)
//   ins_cnt_o, del_cnt_o  : saturating inserted / deleted idle counts
module pcs_loopback_fifo
    import pcs_lb_pkg::*;
#(
    parameter int IS_10G = LB_IS_10G,
    parameter int DATA_W = LB_DATA_W,
    parameter int DEPTH  = 16,
    parameter int HI_WM  = DEPTH - 4,
    parameter int CNT_W  = 16,
    localparam int L0_N   = (IS_10G != 0) ? 2 : 1,
    localparam int K_W    = DATA_W / 8,
    localparam int FILL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              signal_v_i,
    input  logic              valid_i,
    input  logic              ctrl_v_i,
    input  logic              idle_v_i,
    input  logic              term_v_i,
    input  logic              err_v_i,
    input  logic [L0_N-1:0]   start_v_i,
    input  logic [K_W-1:0]    keep_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              ctrl_v_o,
    output logic              idle_v_o,
    output logic              term_v_o,
    output logic              err_v_o,
    output logic [L0_N-1:0]   start_v_o,
    output logic [K_W-1:0]    keep_o,
    output logic [DATA_W-1:0] data_o,
    output logic [FILL_W-1:0] fill_o,
    output logic              ovf_o,
    output logic              udf_o,
    input  logic              clr_i,
    output logic [CNT_W-1:0]  ins_cnt_o,
    output logic [CNT_W-1:0]  del_cnt_o
);

    localparam logic [FILL_W-1:0] HI_WM_F = FILL_W'(HI_WM);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    lb_entry_t         in_entry;
    lb_entry_t         head_entry;
    lb_entry_t         out_q;
    logic [FILL_W-1:0] fill;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr_in_frame;
    logic              rd_in_frame;
    logic              rx_active;
    logic              idle_del;
    logic              write_req;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              rd_frame_live;
    logic              ovf_evt;
    logic              ins_evt;
    logic              udf_evt;
    logic              ovf_q;
    logic              udf_q;
    logic [CNT_W-1:0]  ins_cnt;
    logic [CNT_W-1:0]  del_cnt;

    assign in_entry = '{ctrl:  ctrl_v_i,
                        idle:  idle_v_i,
                        start: start_v_i,
                        term:  term_v_i,
                        err:   err_v_i,
                        keep:  keep_i,
                        data:  data_i};

    // Write side: idles outside a frame are sacrificed once the FIFO is near
    // its high watermark; anything else is stored if there is room.
    assign rx_active = valid_i && signal_v_i;
    assign idle_del  = rx_active && idle_v_i && !wr_in_frame && (fill >= HI_WM_F);
    assign write_req = rx_active && !idle_del;
    assign fifo_rd   = ready_i && signal_v_i && !fifo_empty;
    assign fifo_wr   = write_req && (!fifo_full || fifo_rd);
    assign ovf_evt   = write_req && !fifo_wr;

    // Read side: while the link is down the FIFO looks empty and no frame is
    // considered open, so only idles are produced.
    assign rd_frame_live = rd_in_frame && signal_v_i;
    assign ins_evt       = ready_i && !fifo_rd && !rd_frame_live;
    assign udf_evt       = ready_i && !fifo_rd && rd_frame_live;

    pcs_lb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .flush   (!signal_v_i),
        .wr_en   (fifo_wr),
        .wr_data (in_entry),
        .rd_en   (fifo_rd),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .fill    (fill)
    );

    // Frame trackers. The write side follows every block offered while locked,
    // including dropped ones; the read side follows popped blocks and closes
    // the frame when an error block replaces missing data.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_in_frame <= 1'b0;
            rd_in_frame <= 1'b0;
        end else if (!signal_v_i) begin
            wr_in_frame <= 1'b0;
            rd_in_frame <= 1'b0;
        end else begin
            if (rx_active) begin
                wr_in_frame <= next_in_frame(wr_in_frame, start_v_i, term_v_i);
            end
            if (fifo_rd) begin
                rd_in_frame <= next_in_frame(rd_in_frame, head_entry.start, head_entry.term);
            end else if (udf_evt) begin
                rd_in_frame <= 1'b0;
            end
        end
    end

    // Output register: a new block is loaded only when pcs_tx consumes one.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_q <= IDLE_ENTRY;
        end else if (ready_i) begin
            if (fifo_rd) begin
                out_q <= head_entry;
            end else if (udf_evt) begin
                out_q <= ERR_ENTRY;
            end else begin
                out_q <= IDLE_ENTRY;
            end
        end
    end

    // Sticky flags and saturating counters; a clear beats a same-cycle event.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            ins_cnt <= '0;
            del_cnt <= '0;
        end else if (clr_i) begin
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            ins_cnt <= '0;
            del_cnt <= '0;
        end else begin
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end
            if (udf_evt) begin
                udf_q <= 1'b1;
            end
            if (ins_evt && (ins_cnt != CNT_MAX)) begin
                ins_cnt <= ins_cnt + 1'b1;
            end
            if (idle_del && (del_cnt != CNT_MAX)) begin
                del_cnt <= del_cnt + 1'b1;
            end
        end
    end

    assign ctrl_v_o  = out_q.ctrl;
    assign idle_v_o  = out_q.idle;
    assign term_v_o  = out_q.term;
    assign err_v_o   = out_q.err;
    assign start_v_o = out_q.start;
    assign keep_o    = out_q.keep;
    assign data_o    = out_q.data;
    assign fill_o    = fill;
    assign ovf_o     = ovf_q;
    assign udf_o     = udf_q;
    assign ins_cnt_o = ins_cnt;
    assign del_cnt_o = del_cnt;

endmodule
